// File: rtl/histogram_pkg.sv
// Shared constants for the histogram dataflow stages (compute and reduce).
package histogram_pkg;

  localparam int NUM_BINS = 256;
  localparam int BIN_W    = 8;
  localparam int COUNT_W  = 32;

  // Controller state encoding, kept as plain constants so the reduce stage
  // and older code can reuse the same values.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_RD_IN   = 3'd2;
  localparam logic [2:0] ST_RD_HIST = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;

endpackage

// File: rtl/histogram_compute_if.sv
// ap_ctrl_chain handshake plus sample-memory and bin-memory ports of the
// histogram compute stage. "slave" is the compute block's view.
interface histogram_compute_if #(
  parameter int ADDR_W = 10
);
  import histogram_pkg::*;

  logic               ap_start;
  logic               ap_done;
  logic               ap_continue;
  logic               ap_idle;
  logic               ap_ready;

  logic [ADDR_W-1:0]  in_r_address0;
  logic               in_r_ce0;
  logic [31:0]        in_r_q0;

  logic [BIN_W-1:0]   hist_address0;
  logic               hist_ce0;
  logic               hist_we0;
  logic [COUNT_W-1:0] hist_d0;
  logic [COUNT_W-1:0] hist_q0;

  modport slave (
    input  ap_start, ap_continue, in_r_q0, hist_q0,
    output ap_done, ap_idle, ap_ready,
    output in_r_address0, in_r_ce0,
    output hist_address0, hist_ce0, hist_we0, hist_d0
  );

  modport master (
    output ap_start, ap_continue, in_r_q0, hist_q0,
    input  ap_done, ap_idle, ap_ready,
    input  in_r_address0, in_r_ce0,
    input  hist_address0, hist_ce0, hist_we0, hist_d0
  );

endinterface

// File: rtl/histogram_compute.sv
// Partial 256-bin histogram: clears the bin memory, then does one
// read-modify-write per sample (bin = sample[7:0]). ap_ctrl_chain handshake.
module histogram_compute
  import histogram_pkg::*;
#(
  parameter int N      = 1024,
  parameter int ADDR_W = 10
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  histogram_compute_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_I   = ADDR_W'(N - 1);
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(NUM_BINS - 1);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] i_reg, i_next;
  logic [BIN_W-1:0]  clr_idx_reg, clr_idx_next;
  logic [BIN_W-1:0]  bin_reg, bin_next;
  logic              done_reg, done_next;
  logic              last_wr;

  // Sample bits above the bin index carry no information for this stage.
  logic unused_sample_bits;
  assign unused_sample_bits = ^bus.in_r_q0[31:BIN_W];

  assign last_wr = (state_reg == ST_WR) && (i_reg == LAST_I);

  // Next-state, counters and the sticky done flag (ap_continue wins over set).
  always_comb begin
    state_next   = state_reg;
    i_next       = i_reg;
    clr_idx_next = clr_idx_reg;
    bin_next     = bin_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.ap_start && !done_reg) begin
          clr_idx_next = '0;
          state_next   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr_idx_next = clr_idx_reg + 1'b1;
        if (clr_idx_reg == LAST_BIN) begin
          i_next     = '0;
          state_next = ST_RD_IN;
        end
      end
      ST_RD_IN: begin
        state_next = ST_RD_HIST;
      end
      ST_RD_HIST: begin
        bin_next   = bus.in_r_q0[BIN_W-1:0];
        state_next = ST_WR;
      end
      ST_WR: begin
        if (last_wr) begin
          state_next = ST_IDLE;
        end else begin
          i_next     = i_reg + 1'b1;
          state_next = ST_RD_IN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (bus.ap_continue) begin
      done_next = 1'b0;
    end else if (last_wr) begin
      done_next = 1'b1;
    end else begin
      done_next = done_reg;
    end
  end

  // State and counter registers; reset abandons any run in progress.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg   <= ST_IDLE;
      i_reg       <= '0;
      clr_idx_reg <= '0;
      bin_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      i_reg       <= i_next;
      clr_idx_reg <= clr_idx_next;
      bin_reg     <= bin_next;
      done_reg    <= done_next;
    end
  end

  // Memory strobes decoded from state; nothing is enabled in IDLE.
  always_comb begin
    bus.in_r_ce0      = 1'b0;
    bus.in_r_address0 = '0;
    bus.hist_ce0      = 1'b0;
    bus.hist_we0      = 1'b0;
    bus.hist_address0 = '0;
    bus.hist_d0       = '0;
    case (state_reg)
      ST_CLEAR: begin
        bus.hist_ce0      = 1'b1;
        bus.hist_we0      = 1'b1;
        bus.hist_address0 = clr_idx_reg;
      end
      ST_RD_IN: begin
        bus.in_r_ce0      = 1'b1;
        bus.in_r_address0 = i_reg;
      end
      ST_RD_HIST: begin
        bus.hist_ce0      = 1'b1;
        bus.hist_address0 = bus.in_r_q0[BIN_W-1:0];
      end
      ST_WR: begin
        bus.hist_ce0      = 1'b1;
        bus.hist_we0      = 1'b1;
        bus.hist_address0 = bin_reg;
        bus.hist_d0       = bus.hist_q0 + 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.ap_done  = last_wr | done_reg;
  assign bus.ap_ready = last_wr;
  assign bus.ap_idle  = (state_reg == ST_IDLE) && !bus.ap_start;

endmodule

// File: tb/tb_histogram_compute.sv
// Bench for histogram_compute: three instances (N=4, 1024, 1) sharing a
// clock and reset, each with its own sample and bin memory model.
module tb_histogram_compute;

  logic clk;
  logic rst_n;

  logic        start_v [3];
  logic        cont_v  [3];
  logic        fill_v  [3];
  logic        done_v  [3];
  logic        ready_v [3];
  logic        idle_v  [3];
  logic        ice_v   [3];
  logic        hce_v   [3];
  logic        hwe_v   [3];
  logic [7:0]  haddr_v [3];
  logic [9:0]  iaddr_v [3];

  logic [31:0] smem [3][1024];

  int total = 0;
  int bad   = 0;

  histogram_compute_if #(.ADDR_W(10)) bus [3] ();

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int NI = (gi == 0) ? 4 : ((gi == 1) ? 1024 : 1);
    logic [31:0] hmem [256];

    histogram_compute #(.N(NI), .ADDR_W(10)) dut (
      .ap_clk  (clk),
      .ap_rst_n(rst_n),
      .bus     (bus[gi])
    );

    assign bus[gi].ap_start    = start_v[gi];
    assign bus[gi].ap_continue = cont_v[gi];
    assign done_v[gi]  = bus[gi].ap_done;
    assign ready_v[gi] = bus[gi].ap_ready;
    assign idle_v[gi]  = bus[gi].ap_idle;
    assign ice_v[gi]   = bus[gi].in_r_ce0;
    assign hce_v[gi]   = bus[gi].hist_ce0;
    assign hwe_v[gi]   = bus[gi].hist_we0;
    assign haddr_v[gi] = bus[gi].hist_address0;
    assign iaddr_v[gi] = bus[gi].in_r_address0;

    always @(posedge clk) begin
      if (bus[gi].in_r_ce0) bus[gi].in_r_q0 <= smem[gi][bus[gi].in_r_address0];
    end

    always @(posedge clk) begin
      if (fill_v[gi]) begin
        for (int k = 0; k < 256; k++) hmem[k] <= 32'hDEADBEEF;
      end else if (bus[gi].hist_ce0) begin
        if (bus[gi].hist_we0) hmem[bus[gi].hist_address0] <= bus[gi].hist_d0;
        else bus[gi].hist_q0 <= hmem[bus[gi].hist_address0];
      end
    end
  end

  function automatic logic [31:0] get_bin(input int sel, input int b);
    case (sel)
      0:       return g_inst[0].hmem[b];
      1:       return g_inst[1].hmem[b];
      default: return g_inst[2].hmem[b];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input int sel, input string tag);
    chk({tag, "_done"},  {31'd0, done_v[sel]},  32'd0);
    chk({tag, "_ready"}, {31'd0, ready_v[sel]}, 32'd0);
    chk({tag, "_ice"},   {31'd0, ice_v[sel]},   32'd0);
    chk({tag, "_hce"},   {31'd0, hce_v[sel]},   32'd0);
    chk({tag, "_hwe"},   {31'd0, hwe_v[sel]},   32'd0);
    chk({tag, "_haddr"}, {24'd0, haddr_v[sel]}, 32'd0);
    chk({tag, "_iaddr"}, {22'd0, iaddr_v[sel]}, 32'd0);
    chk({tag, "_idle"},  {31'd0, idle_v[sel]},  {31'd0, ~start_v[sel]});
  endtask

  // Reference: count how many of the first n samples land in each bin.
  task automatic check_bins(input int sel, input int n, input string tag);
    int exp_cnt [256];
    int bad_bins;
    foreach (exp_cnt[b]) exp_cnt[b] = 0;
    for (int k = 0; k < n; k++) exp_cnt[smem[sel][k] % 256]++;
    bad_bins = bad;
    for (int b = 0; b < 256; b++) chk({tag, "_bin"}, get_bin(sel, b), exp_cnt[b]);
    $display("run %s: n=%0d bins checked, %0d wrong", tag, n, bad - bad_bins);
  endtask

  task automatic wait_done(input int sel, input int cyc0, output int cyc);
    cyc = cyc0;
    while (!done_v[sel] && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Entered #1 after a rising edge; that cycle is the accept cycle.
  task automatic run_and_check(input int sel, input int n, input int exp_cyc, input string tag);
    int cyc;
    start_v[sel] = 1'b1;
    cont_v[sel]  = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    wait_done(sel, 1, cyc);
    chk({tag, "_cyc"},    cyc, exp_cyc);
    chk({tag, "_ready1"}, {31'd0, ready_v[sel]}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_ready0"}, {31'd0, ready_v[sel]}, 32'd0);
    chk({tag, "_done0"},  {31'd0, done_v[sel]},  32'd0);
    chk({tag, "_idle"},   {31'd0, idle_v[sel]},  32'd1);
    check_bins(sel, n, tag);
  endtask

  initial begin
    int cyc;
    for (int s = 0; s < 3; s++) begin
      start_v[s] = 1'b0;
      cont_v[s]  = 1'b0;
      fill_v[s]  = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) check_idle_outputs(s, "reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Four identical samples.
    for (int k = 0; k < 4; k++) smem[0][k] = 32'd3;
    run_and_check(0, 4, 268, "same3");

    // Every bin hit exactly four times.
    for (int k = 0; k < 1024; k++) smem[1][k] = k % 256;
    run_and_check(1, 1024, 3328, "ramp");

    // Stale memory must be cleared; upper sample bits ignored.
    fill_v[2] = 1'b1;
    @(posedge clk); #1;
    fill_v[2] = 1'b0;
    chk("prefill", get_bin(2, 17), 32'hDEADBEEF);
    smem[2][0] = 32'h1234_56FF;
    run_and_check(2, 1, 259, "mask");

    // Random full-width samples.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) smem[0][k] = $urandom;
      run_and_check(0, 4, 268, "rand4");
    end
    for (int k = 0; k < 1024; k++) smem[1][k] = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 15);
    run_and_check(1, 1024, 3328, "rand1024");
    smem[2][0] = $urandom;
    run_and_check(2, 1, 259, "rand1");

    // Completion with ap_continue low and ap_start held high.
    for (int k = 0; k < 4; k++) smem[0][k] = $urandom_range(0, 3) | ($urandom << 8);
    start_v[0] = 1'b1;
    cont_v[0]  = 1'b0;
    @(posedge clk); #1;
    wait_done(0, 1, cyc);
    chk("hold_cyc", cyc, 268);
    repeat (12) begin
      @(posedge clk); #1;
      chk("hold_done", {31'd0, done_v[0]}, 32'd1);
      chk("hold_hce",  {31'd0, hce_v[0]},  32'd0);
      chk("hold_ice",  {31'd0, ice_v[0]},  32'd0);
    end
    check_bins(0, 4, "hold");
    cont_v[0] = 1'b1;
    @(posedge clk); #1;
    cont_v[0] = 1'b0;
    chk("cont_done", {31'd0, done_v[0]}, 32'd0);
    chk("cont_hce",  {31'd0, hce_v[0]},  32'd0);
    @(posedge clk); #1;
    chk("rerun_hce",   {31'd0, hce_v[0]},  32'd1);
    chk("rerun_hwe",   {31'd0, hwe_v[0]},  32'd1);
    chk("rerun_haddr", {24'd0, haddr_v[0]}, 32'd0);
    start_v[0] = 1'b0;
    cont_v[0]  = 1'b1;
    wait_done(0, 1, cyc);
    chk("rerun_cyc", cyc, 268);
    @(posedge clk); #1;
    check_bins(0, 4, "rerun");

    // Reset while the first sample's bin read is in flight.
    for (int k = 0; k < 4; k++) smem[0][k] = $urandom;
    start_v[0] = 1'b1;
    cont_v[0]  = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    cyc = 1;
    while (!(hce_v[0] && !hwe_v[0]) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rdhist_cyc", cyc, 258);
    rst_n = 1'b0;
    #1;
    check_idle_outputs(0, "midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs(0, "postrst");
    smem[0][0] = 32'd7;
    smem[0][1] = 32'd7;
    smem[0][2] = 32'd8;
    smem[0][3] = 32'd8;
    run_and_check(0, 4, 268, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
